// File: rtl/druaga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : druaga_pkg
//  Description : Shared constants and types for the Druaga-family ROM
//                download path (region bases, image size, type numbers).
//  Revision    : 1.0 - initial release
// ============================================================================
package druaga_pkg;

  // Base addresses of the DLROM regions inside the download image
  localparam logic [16:0] MCPU_BASE    = 17'h00000;
  localparam logic [16:0] SCPU_BASE    = 17'h10000;
  localparam logic [16:0] WAVE_BASE    = 17'h13500;

  // Image bytes before the trailer; the wave ROM ends at 17'h135FF
  localparam logic [16:0] IMG_SIZE_DEF = 17'h13600;

  // Type number carried by the trailer byte for Super Pacman
  localparam logic [3:0]  TNO_SUPERPAC = 4'd5;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Mod-256 running checksum step
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/druaga_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : druaga_rom_loader
//  Description : Write-side master of the ROMCL/ROMAD/ROMDT/ROMEN download
//                bus. Turns a ready/valid byte stream into one ROMEN pulse
//                per image byte, captures the trailing type number and keeps
//                a running checksum plus done/overrun status.
//  Revision    : 1.0 - initial release
// ============================================================================
module druaga_rom_loader
  import druaga_pkg::*;
#(
  parameter logic [16:0] IMG_SIZE = IMG_SIZE_DEF,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic        ROMCL,
  input  logic        RST_N,
  input  logic        DL_START,
  input  logic        IN_VALID,
  input  logic [7:0]  IN_DATA,
  output logic        IN_READY,
  output logic [16:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic [3:0]  TNO,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERRUN,
  output logic [7:0]  CSUM
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_LOAD = ST_LOAD;
  localparam logic [1:0] S_GAP  = ST_GAP;
  localparam logic [1:0] S_DONE = ST_DONE;

  // The gap counter preloads GAP_CYC-1 because the ROMEN cycle is the first
  // idle cycle of the gap.
  localparam int unsigned   GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned   GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LAST);

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q,   gap_d;
  logic [16:0]   addr_q,  addr_d;
  logic [7:0]    csum_q,  csum_d;
  logic [3:0]    tno_q,   tno_d;
  logic          ovr_q,   ovr_d;
  logic          en_q,    en_d;
  logic [16:0]   ad_q,    ad_d;
  logic [7:0]    dt_q,    dt_d;

  logic          w_ready;
  logic          w_accept;
  logic          w_write;
  logic          w_trailer;

  // A restart request masks the handshake so a byte on that edge is never consumed
  assign w_ready   = ((state_q == S_LOAD) || (state_q == S_DONE)) && !DL_START;
  assign w_accept  = IN_VALID && w_ready;
  assign w_write   = w_accept && (state_q == S_LOAD) && (addr_q < IMG_SIZE);
  assign w_trailer = w_accept && (state_q == S_LOAD) && (addr_q == IMG_SIZE);

  // Next-state logic for the FSM and the inter-write gap counter
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (DL_START) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (w_write) begin
            if (GAP_CYC != 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end
          end else if (w_trailer) begin
            state_d = S_DONE;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_d = S_LOAD;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic for the address counter, write port, checksum and status
  always_comb begin
    addr_d = addr_q;
    csum_d = csum_q;
    tno_d  = tno_q;
    ovr_d  = ovr_q;
    en_d   = 1'b0;
    ad_d   = ad_q;
    dt_d   = dt_q;
    if (DL_START) begin
      addr_d = '0;
      csum_d = '0;
      ovr_d  = 1'b0;
    end else if (w_write) begin
      en_d   = 1'b1;
      ad_d   = addr_q;
      dt_d   = IN_DATA;
      csum_d = csum_add(csum_q, IN_DATA);
      addr_d = addr_q + 17'd1;
    end else if (w_trailer) begin
      tno_d  = IN_DATA[3:0];
    end else if (w_accept && (state_q == S_DONE)) begin
      ovr_d  = 1'b1;
    end
  end

  // State and datapath registers; reset clears everything at once
  always_ff @(posedge ROMCL or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      tno_q   <= '0;
      ovr_q   <= 1'b0;
      en_q    <= 1'b0;
      ad_q    <= '0;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      tno_q   <= tno_d;
      ovr_q   <= ovr_d;
      en_q    <= en_d;
      ad_q    <= ad_d;
      dt_q    <= dt_d;
    end
  end

  assign IN_READY = w_ready;
  assign ROMAD    = ad_q;
  assign ROMDT    = dt_q;
  assign ROMEN    = en_q;
  assign TNO      = tno_q;
  assign BUSY     = (state_q == S_LOAD) || (state_q == S_GAP);
  assign DONE     = (state_q == S_DONE);
  assign OVERRUN  = ovr_q;
  assign CSUM     = csum_q;

endmodule
`default_nettype wire
